// File: rtl/reservoir_pkg.sv
// Shared helpers for the reservoir fill controller: level-width derivation,
// thermometer prefix decode and level-to-valve mapping.
package reservoir_pkg;

  localparam int unsigned MAX_W = 32;

  // Width needed to hold a level in 0..n.
  function automatic int unsigned level_width(input int unsigned n);
    return $clog2(n + 1);
  endfunction

  // Number of consecutive 1s starting from bit 0, over the low n bits.
  function automatic int unsigned therm_prefix_count(input logic [MAX_W-1:0] v,
                                                     input int unsigned n);
    int unsigned cnt;
    logic        run;
    cnt = 0;
    run = 1'b1;
    for (int unsigned i = 0; i < MAX_W; i++) begin
      if (i < n && run && v[i]) cnt = cnt + 1;
      else                      run = 1'b0;
    end
    return cnt;
  endfunction

  // True when the low n bits contain no 1 sitting above a 0.
  function automatic logic is_therm(input logic [MAX_W-1:0] v, input int unsigned n);
    logic seen_zero;
    logic ok;
    seen_zero = 1'b0;
    ok        = 1'b1;
    for (int unsigned i = 0; i < MAX_W; i++) begin
      if (i < n) begin
        if (v[i] && seen_zero) ok = 1'b0;
        if (!v[i])             seen_zero = 1'b1;
      end
    end
    return ok;
  endfunction

  // Valve i stays open while it sits below the n-l unfilled positions.
  function automatic logic [MAX_W-1:0] level_to_fr(input int unsigned l, input int unsigned n);
    logic [MAX_W-1:0] fr;
    fr = '0;
    for (int unsigned i = 0; i < MAX_W; i++) begin
      if (i < n && l <= n && i < n - l) fr[i] = 1'b1;
    end
    return fr;
  endfunction

endpackage

// File: rtl/reservoir_level_ctrl_if.sv
// Sensor/valve bundle between the level controller and its neighbours.
// Fault signals exist only when RESERVOIR_FAULT_DET_EN is defined.
interface reservoir_level_ctrl_if #(
  parameter int unsigned N_LEVELS = 3
);
  import reservoir_pkg::*;

  localparam int unsigned LW = level_width(N_LEVELS);

  logic [N_LEVELS-1:0] s;
  logic [N_LEVELS-1:0] fr;
  logic                dfr;
  logic [LW-1:0]       level;
`ifdef RESERVOIR_FAULT_DET_EN
  logic                fault;
  logic                fault_clr;

  modport master (output s, output fault_clr, input fr, input dfr, input level, input fault);
  modport slave  (input s, input fault_clr, output fr, output dfr, output level, output fault);
`else
  modport master (output s, input fr, input dfr, input level);
  modport slave  (input s, output fr, output dfr, output level);
`endif

endinterface

// File: rtl/sensor_debounce.sv
// Per-vector debouncer: a sensor vector is accepted once it has been seen
// unchanged for DEBOUNCE further edges; commit_c_o is asserted on those edges.
module sensor_debounce #(
  parameter int unsigned N        = 3,
  parameter int unsigned DEBOUNCE = 4
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [N-1:0] s_i,
  output logic [N-1:0] stable_o,
  output logic         commit_c_o
);

  localparam int unsigned   CW      = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE - 1);

  logic [N-1:0]  s_q;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Restart on any change, otherwise count up and hold at the commit value.
  always_comb begin
    cnt_d = cnt_q;
    if (s_i != s_q)            cnt_d = '0;
    else if (cnt_q != CNT_MAX) cnt_d = cnt_q + CW'(1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s_q   <= '0;
      cnt_q <= '0;
    end else begin
      s_q   <= s_i;
      cnt_q <= cnt_d;
    end
  end

  assign stable_o   = s_q;
  assign commit_c_o = (s_i == s_q) && (cnt_q == CNT_MAX);

endmodule

// File: rtl/reservoir_level_ctrl.sv
// Reservoir fill controller: debounced thermometer sensors drive nominal and
// supplemental valves. RESERVOIR_FAULT_DET_EN adds a sticky sensor-fault flag.
module reservoir_level_ctrl
  import reservoir_pkg::*;
#(
  parameter int unsigned N_LEVELS = 3,
  parameter int unsigned DEBOUNCE = 4
) (
  input logic                   clk,
  input logic                   reset_n,
  reservoir_level_ctrl_if.slave bus
);

  localparam int unsigned LW = level_width(N_LEVELS);

  logic [N_LEVELS-1:0] stable;
  logic                commit_c;

  logic [LW-1:0]       level_q, level_d;
  logic                dir_q, dir_d;
  logic [N_LEVELS-1:0] fr_q, fr_d;
  logic                dfr_q, dfr_d;
  logic [LW-1:0]       new_lvl_c;

  sensor_debounce #(
    .N        (N_LEVELS),
    .DEBOUNCE (DEBOUNCE)
  ) u_debounce (
    .clk        (clk),
    .reset_n    (reset_n),
    .s_i        (bus.s),
    .stable_o   (stable),
    .commit_c_o (commit_c)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      level_q <= '0;
      dir_q   <= 1'b0;
      fr_q    <= '1;
      dfr_q   <= 1'b1;
    end else begin
      level_q <= level_d;
      dir_q   <= dir_d;
      fr_q    <= fr_d;
      dfr_q   <= dfr_d;
    end
  end

  // Next (level, dir_down); out-of-range levels collapse to the reset state.
  always_comb begin
    level_d   = level_q;
    dir_d     = dir_q;
    new_lvl_c = LW'(therm_prefix_count(MAX_W'(stable), N_LEVELS));
    if (32'(level_q) > N_LEVELS) begin
      level_d = '0;
      dir_d   = 1'b0;
    end else if (commit_c) begin
      if (new_lvl_c < level_q)      dir_d = 1'b1;
      else if (new_lvl_c > level_q) dir_d = 1'b0;
      level_d = new_lvl_c;
    end
  end

  // Valve outputs decoded from the next state so they register alongside it.
  always_comb begin
    fr_d  = N_LEVELS'(level_to_fr(32'(level_d), N_LEVELS));
    dfr_d = (level_d == '0) | (dir_d & (32'(level_d) < N_LEVELS));
  end

  assign bus.fr    = fr_q;
  assign bus.dfr   = dfr_q;
  assign bus.level = level_q;

`ifdef RESERVOIR_FAULT_DET_EN
  logic fault_q, fault_d;

  // A non-thermometer commit sets the flag and overrides a same-cycle clear.
  always_comb begin
    fault_d = fault_q;
    if (bus.fault_clr) fault_d = 1'b0;
    if (commit_c && !is_therm(MAX_W'(stable), N_LEVELS)) fault_d = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) fault_q <= 1'b0;
    else          fault_q <= fault_d;
  end

  assign bus.fault = fault_q;
`endif

endmodule

// File: tb/tb_reservoir_level_ctrl.sv
// Bench for reservoir_level_ctrl: run-length reference model checked every
// cycle, plus directed scenarios with literal expectations.
module tb_reservoir_level_ctrl;

  localparam int unsigned N = 3;
  localparam int unsigned D = 4;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  reservoir_level_ctrl_if #(.N_LEVELS(N)) bus ();

  reservoir_level_ctrl #(.N_LEVELS(N), .DEBOUNCE(D)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int errors = 0;
  int checks = 0;
  logic cmp_en = 1'b0;

  // Reference model: a vector commits once it has been sampled D+1 times in a row.
  logic [N-1:0] m_last;
  int           m_run;
  int           m_level;
  logic         m_dir;
  logic         m_fault;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_last  = '0;
      m_run   = 1;
      m_level = 0;
      m_dir   = 1'b0;
      m_fault = 1'b0;
    end else begin
      int  l;
      logic above;
      logic bad;
      if (bus.s == m_last) m_run = (m_run > int'(D)) ? m_run : m_run + 1;
      else                 m_run = 1;
      m_last = bus.s;
`ifdef RESERVOIR_FAULT_DET_EN
      if (bus.fault_clr) m_fault = 1'b0;
`endif
      if (m_run >= int'(D) + 1) begin
        l = 0;
        while (l < int'(N) && m_last[l]) l++;
        bad = 1'b0;
        above = 1'b0;
        for (int i = int'(N) - 1; i >= 0; i--) begin
          if (m_last[i]) above = 1'b1;
          else if (above) bad = 1'b1;
        end
        if (l < m_level) m_dir = 1'b1;
        else if (l > m_level) m_dir = 1'b0;
        m_level = l;
        if (bad) m_fault = 1'b1;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Every-cycle comparison of DUT outputs against the model.
  always @(negedge clk) begin
    if (cmp_en) begin
      logic [N-1:0] e_fr;
      logic         e_dfr;
      for (int i = 0; i < int'(N); i++) e_fr[i] = (i < int'(N) - m_level);
      e_dfr = (m_level == 0) || (m_dir && m_level < int'(N));
      chk("cyc_fr", 32'(bus.fr), 32'(e_fr));
      chk("cyc_dfr", 32'(bus.dfr), 32'(e_dfr));
      chk("cyc_level", 32'(bus.level), 32'(m_level));
`ifdef RESERVOIR_FAULT_DET_EN
      chk("cyc_fault", 32'(bus.fault), 32'(m_fault));
`endif
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk_out(input string name, input logic [N-1:0] fr, input logic dfr, input int lvl);
    chk({name, "_fr"}, 32'(bus.fr), 32'(fr));
    chk({name, "_dfr"}, 32'(bus.dfr), 32'(dfr));
    chk({name, "_level"}, 32'(bus.level), 32'(lvl));
  endtask

  initial begin
    bus.s = '0;
`ifdef RESERVOIR_FAULT_DET_EN
    bus.fault_clr = 1'b0;
`endif
    tick(1);
    cmp_en = 1'b1;
    tick(2);
    reset_n = 1'b1;
    tick(2);
    chk_out("reset", 3'b111, 1'b1, 0);

    // Single step up: commit exactly D edges after first sample.
    bus.s = 3'b001;
    tick(D);
    chk_out("pre_commit", 3'b111, 1'b1, 0);
    tick(1);
    chk_out("commit_l1", 3'b011, 1'b0, 1);
    chk("model_l1", 32'(m_level), 32'd1);

    // Climb then drop.
    bus.s = 3'b011; tick(6); chk_out("climb_l2", 3'b001, 1'b0, 2);
    bus.s = 3'b111; tick(6); chk_out("climb_l3", 3'b000, 1'b0, 3);
    bus.s = 3'b011; tick(6); chk_out("drop_l2", 3'b001, 1'b1, 2);
    chk("model_dir", 32'(m_dir), 32'd1);

    // Full level forces dfr low despite falling history.
    bus.s = 3'b111; tick(6); chk_out("full_l3", 3'b000, 1'b0, 3);
    bus.s = 3'b011; tick(6); chk_out("back_l2", 3'b001, 1'b1, 2);

    // Short glitch is ignored; multi-step jump is accepted.
    bus.s = 3'b001; tick(6); chk_out("down_l1", 3'b011, 1'b1, 1);
    bus.s = 3'b011; tick(3);
    bus.s = 3'b001;
    chk_out("glitch_a", 3'b011, 1'b1, 1);
    tick(6);
    chk_out("glitch_b", 3'b011, 1'b1, 1);
    bus.s = 3'b111; tick(6); chk_out("jump_l3", 3'b000, 1'b0, 3);

    // Asynchronous reset partway through a count.
    bus.s = 3'b000;
    tick(3);
    #2 reset_n = 1'b0;
    #1 chk_out("async_rst", 3'b111, 1'b1, 0);
    chk("model_rst", 32'(m_level), 32'd0);
    #2 reset_n = 1'b1;
    tick(6);
    chk_out("post_rst", 3'b111, 1'b1, 0);

`ifdef RESERVOIR_FAULT_DET_EN
    bus.s = 3'b101;
    tick(D);
    chk("fault_pre", 32'(bus.fault), 32'd0);
    tick(1);
    chk_out("fault_l1", 3'b011, 1'b0, 1);
    chk("fault_set", 32'(bus.fault), 32'd1);
    bus.fault_clr = 1'b1; tick(2);
    chk("fault_hold", 32'(bus.fault), 32'd1);
    bus.fault_clr = 1'b0;
    bus.s = 3'b001; tick(6);
    chk("fault_sticky", 32'(bus.fault), 32'd1);
    chk_out("fault_l1b", 3'b011, 1'b0, 1);
    bus.fault_clr = 1'b1; tick(1);
    chk("fault_clr", 32'(bus.fault), 32'd0);
    bus.fault_clr = 1'b0; tick(2);
    chk("fault_stay0", 32'(bus.fault), 32'd0);
`endif

    tick(2);
    cmp_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
